// File: rtl/legv8_pkg.sv
// Shared LEGv8 control definitions: FSM states, opcode patterns and the
// mux/ALU/immediate encodings used by the sign extender and ALU control.
package legv8_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_EX_R    = 4'd2,
    ST_EX_ADDR = 4'd3,
    ST_MEM_RD  = 4'd4,
    ST_MEM_WR  = 4'd5,
    ST_WB_R    = 4'd6,
    ST_WB_LD   = 4'd7,
    ST_BR      = 4'd8,
    ST_CBZ     = 4'd9,
    ST_FAULT   = 4'd10
  } state_e;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_LD  = 3'd1,
    CLS_ST  = 3'd2,
    CLS_B   = 3'd3,
    CLS_CB  = 3'd4,
    CLS_ILL = 3'd5
  } op_class_e;

  // B matches opcode[10:5]; CBZ/CBNZ match opcode[10:3]
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_PASS_B = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;

  localparam logic [1:0] IMM_B  = 2'b00;
  localparam logic [1:0] IMM_CB = 2'b01;
  localparam logic [1:0] IMM_D  = 2'b10;

endpackage

// File: rtl/legv8_opcode_class.sv
// Combinational opcode classifier: instruction class, immediate format and
// illegal flag. Shared by the single-cycle and multicycle control units.
module legv8_opcode_class
  import legv8_pkg::*;
(
  input  logic [10:0] opcode,
  output op_class_e   op_class,
  output logic [1:0]  imm_sel,
  output logic        illegal
);

  // Classify the opcode; the patterns do not overlap so order is cosmetic
  always_comb begin
    op_class = CLS_ILL;
    imm_sel  = IMM_B;
    if (opcode[10:5] == OP_B) begin
      op_class = CLS_B;
      imm_sel  = IMM_B;
    end else if ((opcode[10:3] == OP_CBZ) || (opcode[10:3] == OP_CBNZ)) begin
      op_class = CLS_CB;
      imm_sel  = IMM_CB;
    end else begin
      case (opcode)
        OP_LDUR: begin
          op_class = CLS_LD;
          imm_sel  = IMM_D;
        end
        OP_STUR: begin
          op_class = CLS_ST;
          imm_sel  = IMM_D;
        end
        OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
          op_class = CLS_R;
          imm_sel  = IMM_B;
        end
        default: begin
          op_class = CLS_ILL;
          imm_sel  = IMM_B;
        end
      endcase
    end
  end

  assign illegal = (op_class == CLS_ILL);

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// LEGv8 multicycle control sequencer: Moore FSM driving datapath muxes and
// enables, with a memory-ready handshake, timeout and sticky fault state.
module legv8_multicycle_ctrl
  import legv8_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_is_fetch,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        reg2loc,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  imm_sel,
  output logic [3:0]  state_o,
  output logic        fault
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e     state_r;
  state_e     state_next_s;
  logic [7:0] tmo_cnt_r;
  logic [1:0] imm_sel_r;
  op_class_e  cls_s;
  logic [1:0] dec_imm_s;
  logic       dec_illegal_s;
  logic       mem_req_s;
  logic       tmo_hit_s;

  legv8_opcode_class u_opcode_class (
    .opcode   (opcode),
    .op_class (cls_s),
    .imm_sel  (dec_imm_s),
    .illegal  (dec_illegal_s)
  );

  assign mem_req_s = (state_r == ST_FETCH) || (state_r == ST_MEM_RD) || (state_r == ST_MEM_WR);
  // A ready on the expiring cycle is not a timeout
  assign tmo_hit_s = mem_req_s && !mem_ready && (tmo_cnt_r == TMO_LAST);

  // State register, memory timeout counter and held immediate select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_FETCH;
      tmo_cnt_r <= 8'd0;
      imm_sel_r <= IMM_B;
    end else begin
      state_r <= state_next_s;
      if (!mem_req_s || mem_ready) tmo_cnt_r <= 8'd0;
      else                         tmo_cnt_r <= tmo_cnt_r + 8'd1;
      if (state_r == ST_DECODE) imm_sel_r <= dec_imm_s;
      else                      imm_sel_r <= imm_sel_r;
    end
  end

  // Next-state selection
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (mem_ready)      state_next_s = ST_DECODE;
        else if (tmo_hit_s) state_next_s = ST_FAULT;
        else                state_next_s = ST_FETCH;
      end
      ST_DECODE: begin
        if (dec_illegal_s) begin
          state_next_s = ST_FAULT;
        end else begin
          case (cls_s)
            CLS_R:         state_next_s = ST_EX_R;
            CLS_LD, CLS_ST: state_next_s = ST_EX_ADDR;
            CLS_B:         state_next_s = ST_BR;
            CLS_CB:        state_next_s = ST_CBZ;
            default:       state_next_s = ST_FAULT;
          endcase
        end
      end
      ST_EX_R: state_next_s = ST_WB_R;
      ST_EX_ADDR: begin
        if (cls_s == CLS_ST) state_next_s = ST_MEM_WR;
        else                 state_next_s = ST_MEM_RD;
      end
      ST_MEM_RD: begin
        if (mem_ready)      state_next_s = ST_WB_LD;
        else if (tmo_hit_s) state_next_s = ST_FAULT;
        else                state_next_s = ST_MEM_RD;
      end
      ST_MEM_WR: begin
        if (mem_ready)      state_next_s = ST_FETCH;
        else if (tmo_hit_s) state_next_s = ST_FAULT;
        else                state_next_s = ST_MEM_WR;
      end
      ST_WB_R, ST_WB_LD, ST_BR, ST_CBZ: state_next_s = ST_FETCH;
      ST_FAULT: state_next_s = ST_FAULT;
      default:  state_next_s = ST_FAULT;
    endcase
  end

  // Output decode; held low during reset so no enable can pulse
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    reg2loc      = 1'b0;
    pc_src       = PC_PLUS4;
    alu_src_b    = SRCB_REG;
    alu_op       = ALU_ADD;
    imm_sel      = IMM_B;
    fault        = 1'b0;
    if (!rst_n) begin
      mem_is_fetch = 1'b1;
    end else begin
      imm_sel = imm_sel_r;
      case (state_r)
        ST_FETCH: begin
          mem_req      = 1'b1;
          mem_is_fetch = 1'b1;
          alu_src_b    = SRCB_FOUR;
          ir_write     = mem_ready;
          pc_write     = mem_ready;
        end
        ST_EX_R:  alu_op = ALU_FUNCT;
        ST_WB_R:  reg_write = 1'b1;
        ST_EX_ADDR: begin
          alu_src_b = SRCB_IMM;
          reg2loc   = 1'b1;
        end
        ST_MEM_RD: mem_req = 1'b1;
        ST_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          reg2loc = 1'b1;
        end
        ST_WB_LD: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        ST_BR: begin
          pc_write = 1'b1;
          pc_src   = PC_BRANCH;
        end
        // opcode[3] distinguishes CBNZ from CBZ
        ST_CBZ: begin
          reg2loc  = 1'b1;
          alu_op   = ALU_PASS_B;
          pc_src   = PC_BRANCH;
          pc_write = opcode[3] ? !zero : zero;
        end
        ST_FAULT: fault = 1'b1;
        default:  fault = 1'b0;
      endcase
    end
  end

  assign state_o = state_r;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Bench for legv8_multicycle_ctrl: directed scenarios plus randomized traffic
// checked every cycle against an instruction-level reference model.
module tb_legv8_multicycle_ctrl;

  localparam int T = 16;
  localparam int S_FETCH = 0, S_DECODE = 1, S_EX_R = 2, S_EX_ADDR = 3, S_MEM_RD = 4,
                 S_MEM_WR = 5, S_WB_R = 6, S_WB_LD = 7, S_BR = 8, S_CBZ = 9, S_FAULT = 10;
  localparam int K_R = 0, K_LD = 1, K_ST = 2, K_B = 3, K_CB = 4, K_ILL = 5;

  localparam logic [10:0] C_ADD  = 11'b10001011000;
  localparam logic [10:0] C_LDUR = 11'b11111000010;
  localparam logic [10:0] C_STUR = 11'b11111000000;
  localparam logic [10:0] C_B    = 11'b00010110110;
  localparam logic [10:0] C_CBZ  = 11'b10110100101;
  localparam logic [10:0] C_CBNZ = 11'b10110101011;
  localparam logic [10:0] C_ILL  = 11'b00000000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] opcode = 11'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_is_fetch, ir_write, pc_write, reg_write;
  logic        mem_to_reg, reg2loc, fault;
  logic [1:0]  pc_src, alu_src_b, alu_op, imm_sel;
  logic [3:0]  state_o;

  legv8_multicycle_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_is_fetch(mem_is_fetch),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .reg2loc(reg2loc), .pc_src(pc_src),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_sel(imm_sel),
    .state_o(state_o), .fault(fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (instruction level) ----------------
  int m_step = S_FETCH, m_kind = K_R, m_pos = 0, m_wait = 0, m_imm = 0;

  function automatic int classify(input logic [10:0] op);
    if (op[10:5] == 6'b000101) return K_B;
    if (op[10:4] == 7'b1011010) return K_CB;
    if (op == 11'b11111000010) return K_LD;
    if (op == 11'b11111000000) return K_ST;
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) return K_R;
    return K_ILL;
  endfunction

  function automatic int imm_of(input int kind);
    if (kind == K_LD || kind == K_ST) return 2;
    if (kind == K_CB) return 1;
    return 0;
  endfunction

  // steps an instruction walks after DECODE; -1 means back to fetch
  function automatic int route(input int kind, input int pos);
    case (kind)
      K_R:  return (pos == 0) ? S_EX_R : (pos == 1) ? S_WB_R : -1;
      K_LD: return (pos == 0) ? S_EX_ADDR : (pos == 1) ? S_MEM_RD : (pos == 2) ? S_WB_LD : -1;
      K_ST: return (pos == 0) ? S_EX_ADDR : (pos == 1) ? S_MEM_WR : -1;
      K_B:  return (pos == 0) ? S_BR : -1;
      K_CB: return (pos == 0) ? S_CBZ : -1;
      default: return S_FAULT;
    endcase
  endfunction

  task automatic model_advance();
    int nxt;
    if (m_step == S_FAULT) return;
    if (m_step == S_FETCH || m_step == S_MEM_RD || m_step == S_MEM_WR) begin
      if (!mem_ready) begin
        if (m_wait == T - 1) begin
          m_step = S_FAULT;
          m_wait = 0;
        end else begin
          m_wait++;
        end
        return;
      end
      m_wait = 0;
    end
    if (m_step == S_FETCH) begin
      m_step = S_DECODE;
    end else if (m_step == S_DECODE) begin
      m_kind = classify(opcode);
      m_imm  = imm_of(m_kind);
      m_pos  = 0;
      m_step = route(m_kind, 0);
    end else begin
      m_pos++;
      nxt = route(m_kind, m_pos);
      m_step = (nxt < 0) ? S_FETCH : nxt;
    end
  endtask

  int e_req, e_we, e_fetch, e_ir, e_pcw, e_rw, e_m2r, e_r2l, e_pcsrc, e_srcb, e_aluop, e_imm, e_state, e_fault;

  // every-cycle comparison against the model, then step the model
  always @(negedge clk) begin
    e_req = 0; e_we = 0; e_fetch = 0; e_ir = 0; e_pcw = 0; e_rw = 0; e_m2r = 0;
    e_r2l = 0; e_pcsrc = 0; e_srcb = 0; e_aluop = 0; e_imm = 0; e_state = S_FETCH; e_fault = 0;
    if (!rst_n) begin
      e_fetch = 1;
      m_step = S_FETCH; m_wait = 0; m_imm = 0;
    end else begin
      e_state = m_step;
      e_imm   = m_imm;
      case (m_step)
        S_FETCH:   begin e_req = 1; e_fetch = 1; e_srcb = 1; e_ir = mem_ready; e_pcw = mem_ready; end
        S_EX_R:    e_aluop = 2;
        S_WB_R:    e_rw = 1;
        S_EX_ADDR: begin e_srcb = 2; e_r2l = 1; end
        S_MEM_RD:  e_req = 1;
        S_MEM_WR:  begin e_req = 1; e_we = 1; e_r2l = 1; end
        S_WB_LD:   begin e_rw = 1; e_m2r = 1; end
        S_BR:      begin e_pcw = 1; e_pcsrc = 1; end
        S_CBZ:     begin e_r2l = 1; e_aluop = 1; e_pcsrc = 1; e_pcw = opcode[3] ? !zero : zero; end
        S_FAULT:   e_fault = 1;
        default:   e_fault = 0;
      endcase
    end
    chk("state_o", state_o, e_state);
    chk("mem_req", mem_req, e_req);
    chk("mem_we", mem_we, e_we);
    chk("mem_is_fetch", mem_is_fetch, e_fetch);
    chk("ir_write", ir_write, e_ir);
    chk("pc_write", pc_write, e_pcw);
    chk("reg_write", reg_write, e_rw);
    chk("mem_to_reg", mem_to_reg, e_m2r);
    chk("reg2loc", reg2loc, e_r2l);
    chk("pc_src", pc_src, e_pcsrc);
    chk("alu_src_b", alu_src_b, e_srcb);
    chk("alu_op", alu_op, e_aluop);
    chk("imm_sel", imm_sel, e_imm);
    chk("fault", fault, e_fault);
    if (rst_n) model_advance();
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic rdy, input logic z, input logic [10:0] op);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready = rdy;
    zero = z;
    if (m_step == S_FETCH) opcode = op;
    @(negedge clk);
  endtask

  task automatic cs(input logic rdy, input logic z, input logic [10:0] op, input int st, input string nm);
    cyc(rdy, z, op);
    chk(nm, state_o, st);
  endtask

  task automatic rst_cycle();
    @(posedge clk); #1;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [10:0] rand_op();
    logic [10:0] op;
    op = 11'($urandom);
    case ($urandom_range(0, 8))
      0: op = 11'b10001011000;
      1: op = 11'b11001011000;
      2: op = 11'b10001010000;
      3: op = 11'b10101010000;
      4: op = 11'b11111000010;
      5: op = 11'b11111000000;
      6: op[10:5] = 6'b000101;
      7: op[10:4] = 7'b1011010;
      default: op = op;
    endcase
    return op;
  endfunction

  initial begin
    int p;
    rst_cycle();
    chk("rst_state", state_o, S_FETCH);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_is_fetch", mem_is_fetch, 1);
    chk("rst_ir_write", ir_write, 0);

    // zero-wait ADD: 4 cycles
    cs(1'b1, 1'b0, C_ADD, S_FETCH, "add_fetch");
    cs(1'b1, 1'b0, C_ADD, S_DECODE, "add_decode");
    cs(1'b1, 1'b0, C_ADD, S_EX_R, "add_ex");
    chk("add_alu_op", alu_op, 2);
    cs(1'b1, 1'b0, C_ADD, S_WB_R, "add_wb");
    chk("add_reg_write", reg_write, 1);

    // LDUR with three wait cycles: 8 cycles
    cs(1'b1, 1'b0, C_LDUR, S_FETCH, "ld_fetch");
    cs(1'b1, 1'b0, C_LDUR, S_DECODE, "ld_decode");
    cs(1'b1, 1'b0, C_LDUR, S_EX_ADDR, "ld_ex");
    for (int i = 0; i < 4; i++) begin
      cs((i == 3), 1'b0, C_LDUR, S_MEM_RD, "ld_mem");
      chk("ld_mem_req", {mem_req, mem_we}, 2);
    end
    cs(1'b1, 1'b0, C_LDUR, S_WB_LD, "ld_wb");
    chk("ld_mem_to_reg", mem_to_reg, 1);
    chk("ld_imm_sel", imm_sel, 2);

    // CBZ taken, CBNZ not taken, B: 3 cycles each
    cs(1'b1, 1'b1, C_CBZ, S_FETCH, "cbz_fetch");
    cs(1'b1, 1'b1, C_CBZ, S_DECODE, "cbz_decode");
    cs(1'b1, 1'b1, C_CBZ, S_CBZ, "cbz_state");
    chk("cbz_pc_write", pc_write, 1);
    chk("cbz_pc_src", pc_src, 1);
    chk("cbz_imm_sel", imm_sel, 1);
    cs(1'b1, 1'b1, C_CBNZ, S_FETCH, "cbnz_fetch");
    cs(1'b1, 1'b1, C_CBNZ, S_DECODE, "cbnz_decode");
    cs(1'b1, 1'b1, C_CBNZ, S_CBZ, "cbnz_state");
    chk("cbnz_pc_write", pc_write, 0);
    cs(1'b1, 1'b0, C_B, S_FETCH, "b_fetch");
    cs(1'b1, 1'b0, C_B, S_DECODE, "b_decode");
    cs(1'b1, 1'b0, C_B, S_BR, "b_state");
    chk("b_imm_sel", imm_sel, 0);

    // STUR, then reset asserted mid-wait in MEM_WR
    cs(1'b1, 1'b0, C_STUR, S_FETCH, "st_fetch");
    cs(1'b1, 1'b0, C_STUR, S_DECODE, "st_decode");
    cs(1'b1, 1'b0, C_STUR, S_EX_ADDR, "st_ex");
    chk("st_reg2loc", reg2loc, 1);
    cs(1'b0, 1'b0, C_STUR, S_MEM_WR, "st_mem");
    chk("st_mem_we", mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", state_o, S_FETCH);
    chk("async_mem_we", mem_we, 0);
    chk("async_mem_req", mem_req, 0);
    chk("async_is_fetch", mem_is_fetch, 1);
    @(negedge clk);
    cs(1'b0, 1'b0, C_ADD, S_FETCH, "post_rst_fetch");
    chk("post_rst_mem_we", mem_we, 0);

    // fetch timeout: FAULT decided on cycle 16
    rst_cycle();
    for (int i = 0; i < T; i++) cs(1'b0, 1'b0, C_ADD, S_FETCH, "tmo_wait");
    cs(1'b0, 1'b0, C_ADD, S_FAULT, "tmo_fault");
    chk("tmo_fault_flag", fault, 1);
    rst_cycle();
    for (int i = 0; i < T - 1; i++) cs(1'b0, 1'b0, C_ADD, S_FETCH, "tmo2_wait");
    cs(1'b1, 1'b0, C_ADD, S_FETCH, "tmo2_ready");
    cs(1'b1, 1'b0, C_ADD, S_DECODE, "tmo2_decode");
    chk("tmo2_fault_flag", fault, 0);

    // illegal opcode: sticky fault with all enables low
    rst_cycle();
    cs(1'b1, 1'b0, C_ILL, S_FETCH, "ill_fetch");
    cs(1'b1, 1'b0, C_ILL, S_DECODE, "ill_decode");
    for (int i = 0; i < 20; i++) begin
      cs(1'b1, 1'b1, C_ILL, S_FAULT, "ill_fault");
      chk("ill_enables", {fault, ir_write, pc_write, reg_write, mem_req, mem_we}, 32);
    end
    rst_cycle();
    cs(1'b1, 1'b0, C_ADD, S_FETCH, "ill_recover");

    // randomized traffic, with slow-memory windows that provoke timeouts
    for (int i = 0; i < 4000; i++) begin
      p = (((i / 400) % 3) == 2) ? 1 : 7;
      if (m_step == S_FAULT || $urandom_range(0, 299) == 0) rst_cycle();
      else cyc($urandom_range(0, 9) < p, 1'($urandom_range(0, 1)), rand_op());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
